pe_seq: RTL and testbench
=========================

Name: pe_seq

Overview:
- Sequencer that drives one pe_my processing element through a full dot-product job, acting as the initiator on the PE's port interface.
- Loads a B vector into the PE's local RAM, then streams the matching A elements one at a time.
- Waits for each multiply-accumulate to return before issuing the next element, because the PE accumulator is fed back.
- Presents the final sum on an output stream. Sits between the host-side input stream and a PE.

Parameters:
- L_RAM_SIZE, 6, PE RAM address width; vector length N = 2**L_RAM_SIZE.
- TIMEOUT, 64, maximum cycles to wait for pe_dvalid after an issue before flagging an error.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- start  in  1  single-cycle job start; ignored unless the FSM is in IDLE.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag; cleared when the next start is accepted.
- s_tdata  in  32  input words: first N are B, next N are A.
- s_tvalid  in  1  input word valid.
- s_tready  out  1  input word accepted when s_tvalid and s_tready are both high.
- m_tdata  out  32  result (IEEE-754 single).
- m_tvalid  out  1  result valid.
- m_tready  in  1  result consumer ready.
- pe_aresetn  out  1  PE reset, active low.
- pe_din  out  32  PE RAM write data.
- pe_addr  out  L_RAM_SIZE  PE RAM address.
- pe_we  out  1  PE RAM write enable.
- pe_ain  out  32  PE port A operand.
- pe_valid  out  1  PE integrated valid.
- pe_dvalid  in  1  PE result valid.
- pe_dout  in  32  PE result.

Behaviour:
- Reset values: all PE-side outputs are registers, all 0. pe_aresetn=0, s_tready=0, m_tvalid=0, m_tdata=0, err=0, busy=0. Reset mid-job aborts to IDLE.
- IDLE:
  - pe_aresetn=1.
  - start -> CLR; clears err, k=0.
- CLR: pe_aresetn=0 for exactly 2 cycles (FP IP minimum), which zeroes the PE accumulator. Then -> LOAD_B.
- LOAD_B:
  - s_tready=1.
  - Each handshake: next cycle pe_we=1, pe_addr=cnt, pe_din=s_tdata; otherwise pe_we=0.
  - cnt increments 0..N-1. After handshake N-1 -> CALC_RD with k=0. The final write still occurs on the first cycle of CALC_RD.
- CALC_RD:
  - s_tready=0, pe_we=0, pe_addr<=k.
  - Stays exactly 2 cycles: 1 cycle for the registered address, 1 cycle for the RAM read. Then -> CALC_ISSUE.
- CALC_ISSUE:
  - s_tready=1, pe_addr held at k.
  - On handshake: next cycle pe_ain=s_tdata, pe_valid=1 for exactly one cycle. Then -> CALC_WAIT with the wait counter cleared.
  - Gaps in s_tvalid: remain in CALC_ISSUE indefinitely.
- CALC_WAIT:
  - pe_addr held at k, s_tready=0.
  - pe_dvalid: capture pe_dout into the result register. If k==N-1 -> RESULT, else k++ -> CALC_RD.
  - Wait counter reaches TIMEOUT without pe_dvalid -> ERR.
  - pe_dvalid in any other state is ignored.
- RESULT:
  - m_tvalid=1, m_tdata = the last captured pe_dout, held stable until m_tready.
  - On handshake: m_tvalid=0 next cycle -> IDLE.
- ERR: err<=1 -> IDLE next cycle; m_tvalid stays 0.
- start in any state except IDLE is ignored. start and m_tready in the same RESULT cycle: return to IDLE only; start is not latched.
- Latency per element: 2 (CALC_RD) + 1 (issue) + PE latency + 1.
- No arithmetic in this block; data passes through bit-exact.

Test Plan:
1. L_RAM_SIZE=2 (N=4), PE model with 5-cycle FP MAC. B={0x3F800000,0x40000000,0x40400000,0x40800000}, A=4×0x3F800000 -> single m_tvalid beat with m_tdata=0x41200000 (10.0); pe_valid pulses exactly 4 times, each one cycle.
2. Back-to-back jobs, second B=4×0x40000000, A=4×0x3F800000 -> pe_aresetn low exactly 2 cycles at the job start; result 0x41000000 (8.0), proving the clear.
3. Random s_tvalid gaps (1-3 cycles) during load and calc -> the PE RAM write sequence is addr 0..3 with correct data; result unchanged at 0x41200000.
4. m_tready held low 5 cycles in RESULT -> m_tdata/m_tvalid stable; busy=1 until the handshake; start pulses meanwhile are ignored.
5. PE model never asserts pe_dvalid, TIMEOUT=8 -> err=1 exactly 8 cycles after the pe_valid pulse, then IDLE (busy=0, m_tvalid=0); the next start clears err.
6. areset asserted during CALC_WAIT -> all outputs at reset values immediately; after release, a full job per test 1 yields 0x41200000.

Source files
------------

// File: rtl/pe_seq.sv
// -----------------------------------------------------------------------------
// pe_seq
//
// Drives one pe_my processing element through a complete dot-product job.
// The block acts as the initiator on the PE port interface:
//   1. pulls the PE out of reset for a two-cycle clear of its accumulator,
//   2. streams N = 2**L_RAM_SIZE B words from the host stream into PE RAM,
//   3. for each k, reads B[k] from PE RAM, issues A[k] on port A, and waits
//      for the PE's pe_dvalid before the next element. The PE accumulator is
//      fed back, so only one multiply-accumulate may be in flight at a time,
//   4. offers the final accumulator value on the result stream.
// No arithmetic happens here; data words pass through bit-exact.
//
// Ports
//   aclk, areset           clock, asynchronous active-high reset
//   start                  single-cycle job request, honoured only in IDLE
//   busy                   high whenever the sequencer is not IDLE
//   err                    sticky PE timeout flag, cleared by the next start
//   s_tdata/tvalid/tready  host input stream: N B words, then N A words
//   m_tdata/tvalid/tready  result stream (IEEE-754 single)
//   pe_aresetn             PE reset, active low
//   pe_din/pe_addr/pe_we   PE RAM write port (pe_addr also selects the read)
//   pe_ain/pe_valid        PE operand A and its one-cycle valid
//   pe_dvalid/pe_dout      PE result
// -----------------------------------------------------------------------------
module pe_seq #(
    parameter int L_RAM_SIZE = 6,
    parameter int TIMEOUT    = 64
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  start,
    output logic                  busy,
    output logic                  err,

    input  logic [31:0]           s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,

    output logic [31:0]           m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,

    output logic                  pe_aresetn,
    output logic [31:0]           pe_din,
    output logic [L_RAM_SIZE-1:0] pe_addr,
    output logic                  pe_we,
    output logic [31:0]           pe_ain,
    output logic                  pe_valid,
    input  logic                  pe_dvalid,
    input  logic [31:0]           pe_dout
);

    // Wait counter must be able to hold TIMEOUT-1.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Index of the last vector element (N-1).
    localparam logic [L_RAM_SIZE-1:0] LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_B,
        S_CALC_RD,
        S_CALC_ISSUE,
        S_CALC_WAIT,
        S_RESULT,
        S_ERR
    } state_t;

    state_t                state_reg;
    logic [L_RAM_SIZE-1:0] cnt_reg;      // B load index
    logic [L_RAM_SIZE-1:0] k_reg;        // current element index
    logic                  phase_reg;    // second cycle of CLR / CALC_RD
    logic [WW-1:0]         wait_cnt_reg; // cycles spent in CALC_WAIT

    logic s_hs;
    assign s_hs = s_tvalid & s_tready;

    // busy is a pure decode of the state register, so it is glitch-free and
    // reads 0 during reset along with the state.
    assign busy = (state_reg != S_IDLE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            k_reg        <= '0;
            phase_reg    <= 1'b0;
            wait_cnt_reg <= '0;
            err          <= 1'b0;
            s_tready     <= 1'b0;
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            pe_aresetn   <= 1'b0;
            pe_din       <= '0;
            pe_addr      <= '0;
            pe_we        <= 1'b0;
            pe_ain       <= '0;
            pe_valid     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            pe_we    <= 1'b0;
            pe_valid <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    pe_aresetn <= 1'b1;
                    s_tready   <= 1'b0;
                    if (start) begin
                        err        <= 1'b0;
                        k_reg      <= '0;
                        cnt_reg    <= '0;
                        phase_reg  <= 1'b0;
                        // Drop PE reset now so it is low for both CLR cycles.
                        pe_aresetn <= 1'b0;
                        state_reg  <= S_CLR;
                    end
                end

                S_CLR: begin
                    // Two cycles of PE reset: the FP IP needs at least two.
                    pe_aresetn <= 1'b0;
                    if (phase_reg) begin
                        phase_reg  <= 1'b0;
                        pe_aresetn <= 1'b1;
                        s_tready   <= 1'b1;
                        state_reg  <= S_LOAD_B;
                    end else begin
                        phase_reg <= 1'b1;
                    end
                end

                S_LOAD_B: begin
                    if (s_hs) begin
                        pe_we   <= 1'b1;
                        pe_addr <= cnt_reg;
                        pe_din  <= s_tdata;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST) begin
                            // Final write lands in the first CALC_RD cycle.
                            s_tready  <= 1'b0;
                            k_reg     <= '0;
                            phase_reg <= 1'b0;
                            state_reg <= S_CALC_RD;
                        end
                    end
                end

                S_CALC_RD: begin
                    // Cycle 0 registers the address, cycle 1 lets the PE RAM
                    // register its read data; B[k] is valid in CALC_ISSUE.
                    s_tready <= 1'b0;
                    pe_addr  <= k_reg;
                    if (phase_reg) begin
                        phase_reg <= 1'b0;
                        s_tready  <= 1'b1;
                        state_reg <= S_CALC_ISSUE;
                    end else begin
                        phase_reg <= 1'b1;
                    end
                end

                S_CALC_ISSUE: begin
                    pe_addr <= k_reg;
                    if (s_hs) begin
                        pe_ain       <= s_tdata;
                        pe_valid     <= 1'b1;
                        s_tready     <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= S_CALC_WAIT;
                    end
                end

                S_CALC_WAIT: begin
                    pe_addr  <= k_reg;
                    s_tready <= 1'b0;
                    if (pe_dvalid) begin
                        // m_tdata doubles as the result register; m_tvalid is
                        // low here so updating it is invisible downstream.
                        m_tdata <= pe_dout;
                        if (k_reg == LAST) begin
                            m_tvalid  <= 1'b1;
                            state_reg <= S_RESULT;
                        end else begin
                            k_reg     <= k_reg + 1'b1;
                            phase_reg <= 1'b0;
                            state_reg <= S_CALC_RD;
                        end
                    end else if (wait_cnt_reg == WW'(TIMEOUT - 1)) begin
                        // err is raised on entry to ERR so it appears exactly
                        // TIMEOUT cycles after the pe_valid pulse.
                        err       <= 1'b1;
                        state_reg <= S_ERR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                S_RESULT: begin
                    if (m_tready) begin
                        m_tvalid  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end

                S_ERR: begin
                    err       <= 1'b1;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_seq.sv
// -----------------------------------------------------------------------------
// tb_pe_seq
//
// Bench for pe_seq with N = 4 and TIMEOUT = 8. A behavioural PE stands in for
// pe_my: RAM with registered read, and a 5-cycle multiply-accumulate whose
// accumulator is cleared while pe_aresetn is low. Jobs come from a small table
// of {B, A, gaps, expected result}; multi-cycle corner cases are hand-written.
// -----------------------------------------------------------------------------
module tb_pe_seq;

    localparam int L = 2;
    localparam int N = 4;
    localparam int TO = 8;

    logic         aclk = 1'b0;
    logic         areset;
    logic         start;
    logic         busy;
    logic         err;
    logic [31:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         pe_aresetn;
    logic [31:0]  pe_din;
    logic [L-1:0] pe_addr;
    logic         pe_we;
    logic [31:0]  pe_ain;
    logic         pe_valid;
    logic         pe_dvalid;
    logic [31:0]  pe_dout;

    always #5 aclk = ~aclk;

    pe_seq #(.L_RAM_SIZE(L), .TIMEOUT(TO)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .start      (start),
        .busy       (busy),
        .err        (err),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .pe_aresetn (pe_aresetn),
        .pe_din     (pe_din),
        .pe_addr    (pe_addr),
        .pe_we      (pe_we),
        .pe_ain     (pe_ain),
        .pe_valid   (pe_valid),
        .pe_dvalid  (pe_dvalid),
        .pe_dout    (pe_dout)
    );

    // ---------------- float helpers (normal numbers and zero) ----------------
    function automatic real sp2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // ---------------- behavioural PE ----------------
    logic [31:0] pe_ram [N];
    logic [31:0] pe_rd;
    logic [4:0]  vpipe;
    logic [31:0] dpipe [5];
    real         acc;
    bit          no_dv = 1'b0;

    always @(posedge aclk) begin
        if (pe_we) pe_ram[pe_addr] <= pe_din;
        pe_rd <= pe_ram[pe_addr];
        if (!pe_aresetn) begin
            acc = 0.0;
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[3:0], pe_valid & ~no_dv};
            for (int i = 4; i > 0; i--) dpipe[i] <= dpipe[i-1];
            if (pe_valid) begin
                acc = acc + sp2r(pe_ain) * sp2r(pe_rd);
                dpipe[0] <= r2sp(acc);
            end
        end
    end
    assign pe_dvalid = vpipe[4];
    assign pe_dout   = dpipe[4];

    // ---------------- monitors (sample on falling edge) ----------------
    int          cyc = 0;
    int          pv_count, pv_long, pv_cyc, err_cyc, lo_run, lo_last, mt_rise;
    bit          pv_prev = 1'b0, err_prev = 1'b0, mt_prev = 1'b0;
    logic [L-1:0] wr_addr [$];
    logic [31:0] wr_data [$];

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (pe_valid) begin
            pv_count++;
            if (pv_prev) pv_long++;
            pv_cyc = cyc;
        end
        pv_prev = pe_valid;
        if (!pe_aresetn) lo_run++;
        else if (lo_run != 0) begin
            lo_last = lo_run;
            lo_run  = 0;
        end
        if (pe_we) begin
            wr_addr.push_back(pe_addr);
            wr_data.push_back(pe_din);
        end
        if (m_tvalid && !mt_prev) mt_rise++;
        mt_prev = m_tvalid;
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;
    end

    // ---------------- checking ----------------
    int tests  = 0;
    int failed = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    typedef struct {
        string           name;
        logic [3:0][31:0] b;
        logic [3:0][31:0] a;
        bit              gaps;
        logic [31:0]     exp;
    } vec_t;

    vec_t tbl [3];

    // Present one word and hold it until accepted (bounded).
    task automatic send_word(input logic [31:0] w, input bit gaps);
        int n;
        if (gaps) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge aclk);
        end
        s_tvalid = 1'b1;
        s_tdata  = w;
        n = 0;
        while (!s_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 200) chk("s_tready_timeout", 32'(s_tready), 32'd1);
        @(negedge aclk);
        s_tvalid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    // Run a full job; hold keeps m_tready low that many cycles in RESULT while
    // start is pulsed (must be ignored).
    task automatic do_job(input vec_t v, input int hold);
        int n;
        logic [31:0] res;
        pv_count = 0; pv_long = 0; lo_last = 0; mt_rise = 0;
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        chk({v.name, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({v.name, "_err_cleared"}, 32'(err), 32'd0);
        for (int i = 0; i < N; i++) send_word(v.b[i], v.gaps);
        for (int i = 0; i < N; i++) send_word(v.a[i], v.gaps);
        n = 0;
        while (!m_tvalid && n < 200) begin
            @(negedge aclk);
            n++;
        end
        chk({v.name, "_m_tvalid"}, 32'(m_tvalid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            chk({v.name, "_hold_valid"}, 32'(m_tvalid), 32'd1);
            chk({v.name, "_hold_data"}, m_tdata, v.exp);
            chk({v.name, "_hold_busy"}, 32'(busy), 32'd1);
            start = (h == 1 || h == 3);
            @(negedge aclk);
            start = 1'b0;
        end
        res = m_tdata;
        m_tready = 1'b1;
        @(negedge aclk);
        m_tready = 1'b0;
        $display("[TB] job %s: result %h (expected %h)", v.name, res, v.exp);
        chk({v.name, "_result"}, res, v.exp);
        chk({v.name, "_m_tvalid_dropped"}, 32'(m_tvalid), 32'd0);
        repeat (2) begin
            chk({v.name, "_idle_after"}, 32'(busy), 32'd0);
            @(negedge aclk);
        end
        chk({v.name, "_pe_valid_count"}, 32'(pv_count), 32'(N));
        chk({v.name, "_pe_valid_long"}, 32'(pv_long), 32'd0);
        chk({v.name, "_pe_reset_len"}, 32'(lo_last), 32'd2);
        chk({v.name, "_result_beats"}, 32'(mt_rise), 32'd1);
        chk({v.name, "_write_count"}, 32'(wr_addr.size()), 32'(N));
        for (int i = 0; i < N && i < wr_addr.size(); i++) begin
            chk({v.name, "_wr_addr"}, 32'(wr_addr[i]), 32'(i));
            chk({v.name, "_wr_data"}, wr_data[i], v.b[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0].name = "basic";
        tbl[0].b    = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        tbl[0].a    = {4{32'h3F800000}};
        tbl[0].gaps = 1'b0;
        tbl[0].exp  = 32'h41200000;   // 1+2+3+4 = 10.0
        tbl[1].name = "cleared";
        tbl[1].b    = {4{32'h40000000}};
        tbl[1].a    = {4{32'h3F800000}};
        tbl[1].gaps = 1'b0;
        tbl[1].exp  = 32'h41000000;   // 8.0, not 18.0
        tbl[2].name = "gaps";
        tbl[2].b    = tbl[0].b;
        tbl[2].a    = tbl[0].a;
        tbl[2].gaps = 1'b1;
        tbl[2].exp  = 32'h41200000;

        areset = 1'b1; start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        pv_count = 0; pv_long = 0; pv_cyc = 0; err_cyc = 0; lo_run = 0; lo_last = 0; mt_rise = 0;
        repeat (3) @(negedge aclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pe_aresetn", 32'(pe_aresetn), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        chk("idle_pe_aresetn", 32'(pe_aresetn), 32'd1);

        // Tests 1-3: table-driven jobs, back to back.
        for (int i = 0; i < 3; i++) do_job(tbl[i], 0);

        // Test 4: stalled result consumer with ignored start pulses.
        do_job(tbl[0], 5);

        // Test 5: PE never answers.
        no_dv = 1'b1;
        pulse_start();
        for (int i = 0; i < N; i++) send_word(tbl[0].b[i], 1'b0);
        send_word(tbl[0].a[0], 1'b0);
        n = 0;
        while (!err && n < 50) begin
            @(negedge aclk);
            n++;
        end
        #1;
        $display("[TB] timeout job: err rose %0d cycles after pe_valid", err_cyc - pv_cyc);
        chk("timeout_err_set", 32'(err), 32'd1);
        chk("timeout_latency", 32'(err_cyc - pv_cyc), 32'(TO));
        @(negedge aclk);
        chk("timeout_idle_busy", 32'(busy), 32'd0);
        chk("timeout_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("timeout_err_sticky", 32'(err), 32'd1);
        no_dv = 1'b0;
        do_job(tbl[0], 0);   // start clears err, normal result follows

        // Test 6: reset while waiting for the PE.
        pv_count = 0;
        pulse_start();
        for (int i = 0; i < N; i++) send_word(tbl[0].b[i], 1'b0);
        send_word(tbl[0].a[0], 1'b0);
        n = 0;
        while (pv_count == 0 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 areset = 1'b1;
        #1;
        $display("[TB] reset asserted in CALC_WAIT");
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_s_tready", 32'(s_tready), 32'd0);
        chk("arst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("arst_m_tdata", m_tdata, 32'd0);
        chk("arst_pe_aresetn", 32'(pe_aresetn), 32'd0);
        chk("arst_pe_we", 32'(pe_we), 32'd0);
        chk("arst_pe_valid", 32'(pe_valid), 32'd0);
        chk("arst_pe_addr", 32'(pe_addr), 32'd0);
        chk("arst_pe_din", pe_din, 32'd0);
        chk("arst_pe_ain", pe_ain, 32'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        do_job(tbl[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
